// File: rtl/muldiv_ctrl.sv
// Purpose : sequencer for the shared mult/div unit; signed shift-add multiply or restoring divide into HI/LO.
// Latency : done 33 cycles after the accepted start (WIDTH iterations + final sign fix); divide-by-zero reports after 1 cycle.
// Backpres: single operation in flight; start is ignored while busy is high (no queueing).
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   start, op, op_a, op_b       one-cycle request; op 0 = signed mult, 1 = signed div
//   busy, done, div_zero        status; done/div_zero are one-cycle pulses
//   hilo_write, hi, lo          result strobe and registered HI/LO (held between completions)
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hilo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIN  = 3'd3,
        S_DZ   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand magnitudes. a_mag is the multiplicand, or the dividend that is
    // shifted out while quotient bits are shifted in. b_mag is the multiplier
    // (shifted right each step) or the divisor (constant).
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    // Multiply: full 2*WIDTH product accumulator. Divide: upper half is the
    // partial remainder, lower half unused.
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res;
    logic               neg_rem;
    logic               is_div;

    logic               last_iter;

    // Request-side magnitudes; unary minus keeps the most negative value
    // correct as an unsigned magnitude.
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // Multiply step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [2*WIDTH-1:0] mul_res;

    // Divide step
    logic [WIDTH-1:0]   rem;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               trial_ok;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    // Registered-output next values
    logic               busy_nxt;
    logic               done_nxt;
    logic               div_zero_nxt;
    logic               hilo_write_nxt;
    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;

    assign a_abs = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_abs = op_b[WIDTH-1] ? -op_b : op_b;

    // Counter holds the number of iterations already done; the edge that
    // performs iteration WIDTH moves to FIN.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Add into the upper half with the carry kept in bit WIDTH, then the
    // whole accumulator shifts right so the carry lands in the top bit.
    assign mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_mag[0] ? {1'b0, a_mag} : '0);
    assign mul_acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    assign mul_res     = neg_res ? -acc : acc;

    // Restoring divide: shift {rem, quo} left, try subtracting the divisor
    // and keep the difference only when it does not go negative. One spare
    // bit on top of the trial makes the borrow an explicit sign bit.
    assign rem      = acc[2*WIDTH-1:WIDTH];
    assign rem_sh   = {rem, a_mag[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, b_mag};
    assign trial_ok = ~trial[WIDTH+1];
    assign rem_nxt  = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt  = {a_mag[WIDTH-2:0], trial_ok};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end else if (!op) begin
                    state_nxt = S_MULT;
                end else if (op_b == '0) begin
                    state_nxt = S_DZ;
                end else begin
                    state_nxt = S_DIV;
                end
            end
            S_MULT:  state_nxt = last_iter ? S_FIN : S_MULT;
            S_DIV:   state_nxt = last_iter ? S_FIN : S_DIV;
            S_FIN:   state_nxt = S_IDLE;
            S_DZ:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        div_zero_nxt   = 1'b0;
        hilo_write_nxt = 1'b0;
        hi_nxt         = hi;
        lo_nxt         = lo;
        case (state)
            S_IDLE: begin
                busy_nxt = start;
            end
            S_MULT, S_DIV: begin
                busy_nxt = 1'b1;
            end
            S_FIN: begin
                done_nxt       = 1'b1;
                hilo_write_nxt = 1'b1;
                if (is_div) begin
                    // Quotient truncates toward zero; remainder takes the dividend's sign.
                    lo_nxt = neg_res ? -a_mag : a_mag;
                    hi_nxt = neg_rem ? -rem : rem;
                end else begin
                    hi_nxt = mul_res[2*WIDTH-1:WIDTH];
                    lo_nxt = mul_res[WIDTH-1:0];
                end
            end
            S_DZ: begin
                done_nxt     = 1'b1;
                div_zero_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hilo_write <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            busy       <= busy_nxt;
            done       <= done_nxt;
            div_zero   <= div_zero_nxt;
            hilo_write <= hilo_write_nxt;
            hi         <= hi_nxt;
            lo         <= lo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Operands are captured only here, so a start while busy
                    // cannot disturb the operation in flight.
                    if (start) begin
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_rem <= op_a[WIDTH-1];
                        is_div  <= op;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                S_MULT: begin
                    acc   <= mul_acc_nxt;
                    b_mag <= {1'b0, b_mag[WIDTH-1:1]};
                    cnt   <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    acc   <= {rem_nxt, acc[WIDTH-1:0]};
                    a_mag <= quo_nxt;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Purpose : self-checking bench for muldiv_ctrl against a plain-arithmetic signed mult/div model.
// Latency : checks busy/done every cycle of each operation and HI/LO on the completion cycle.
// Backpres: exercises ignored starts while busy and a reset in the middle of a divide.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] op_a  = '0;
    logic [W-1:0] op_b  = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         hilo_write;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural HI/LO as the model sees them.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hilo_write (hilo_write),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: signed 64-bit arithmetic. Division truncates toward zero and
    // the remainder follows the dividend, which matches SV's / and %.
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic dz);
        longint       sa;
        longint       sb;
        longint       q;
        longint       r;
        logic [63:0]  p;
        sa = $signed(a);
        sb = $signed(b);
        dz = o && (b == '0);
        if (!o) begin
            p    = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (!dz) begin
            q    = sa / sb;
            r    = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
    endtask

    // Issue one operation and follow it cycle by cycle. inj > 0 pulses a
    // second start (with junk operands) at that cycle of the operation.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        logic dz;
        int   lat;
        model(o, a, b, dz);
        lat = dz ? 1 : 33;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        // Start edge has passed: scramble the inputs, they must not matter.
        start = 1'b0;
        op    = 1'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
        check("busy_after_start", {busy, done}, 2'b10);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("running", {busy, done, hilo_write, div_zero}, 4'b1000);
            start = (k == inj);
            if (k == inj) begin
                op   = 1'($urandom);
                op_a = $urandom;
                op_b = $urandom;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("complete_flags", {busy, done, hilo_write, div_zero}, {1'b0, 1'b1, !dz, dz});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        @(negedge clk);
        check("after_done", {busy, done, hilo_write, div_zero}, 4'b0000);
        check("hi_hold", hi, m_hi);
        check("lo_hold", lo, m_lo);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = '0;
            1:       v = W'($urandom_range(1, 15));
            2:       v = -W'($urandom_range(1, 15));
            3:       v = 32'h8000_0000;
            4:       v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2 reset = 1'b0;
        #20;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_hilo_write", hilo_write, 1'b0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        @(negedge clk);
        reset = 1'b1;

        // 7 * -3 = -21
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        // -7 / 2 = -3 rem -1
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        // preload 3*4, then divide by zero leaves HI/LO alone
        do_op(1'b0, 32'd3, 32'd4, 0);
        do_op(1'b1, 32'd5, 32'd0, 0);
        // wrap cases
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        // stray start in the middle of a multiply
        do_op(1'b0, 32'h0001_2345, 32'hFFFF_0001, 10);

        // reset at cycle 15 of a divide: abandoned, no completion
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_flags", {busy, done, hilo_write, div_zero}, 4'b0000);
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("midrst_no_done", {busy, done, hilo_write}, 3'b000);
        end
        do_op(1'b1, 32'd100, 32'd7, 0);

        // random operations
        for (int i = 0; i < 25; i++) begin
            logic         ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 1'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            do_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the multicycle core's mult/div resource.
- Accepts a one-cycle start from the main control unit and runs a 32-iteration shift-add multiply or restoring divide.
- Drives HI/LO with a write strobe, reports completion, and flags divide-by-zero so the main controller can enter exception handling.
- Only one operation in flight at a time. The main controller stalls on busy.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH each, iteration count = WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while busy=0
op  input  1  0 = signed mult, 1 = signed div
op_a  input  WIDTH  multiplicand / dividend (rs)
op_b  input  WIDTH  multiplier / divisor (rt)
busy  output  1  operation in progress; start is ignored while high
done  output  1  one-cycle completion pulse
div_zero  output  1  one-cycle pulse, coincident with done, divisor was 0
hilo_write  output  1  one-cycle strobe, coincident with done, hi/lo updated
hi  output  WIDTH  mult: product[63:32]; div: remainder
lo  output  WIDTH  mult: product[31:0]; div: quotient

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, div_zero, hilo_write = 0; hi = lo = 0; counter and internal registers = 0. Reset mid-operation abandons the operation and produces no done.
- States: IDLE, MULT, DIV, FIN, DZ. All outputs are registered.
- IDLE, start=1 at edge E0:
  - Latch |op_a| and |op_b| (unsigned magnitudes).
  - Latch neg_res = sign(a) XOR sign(b) and neg_rem = sign(a).
  - Clear the accumulator and set count=0.
  - Next state: MULT if op=0; DZ if op=1 and op_b=0; otherwise DIV.
  - busy=1 from E0.
- MULT, one iteration per edge E1..E32:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator (carry kept).
  - Shift the accumulator right 1 and shift the multiplier right 1.
  - count++. When count reaches WIDTH-1 on an edge, next state is FIN.
- DIV, restoring division, one iteration per edge E1..E32:
  - {rem, quo} shifted left 1; trial = rem - divisor (WIDTH+1 bits).
  - If trial >= 0: rem = trial and quo LSB = 1; else quo LSB = 0.
  - Same counter rule as MULT.
- FIN, at edge E33:
  - mult: {hi, lo} = neg_res ? -acc : acc (2*WIDTH two's complement).
  - div: lo = neg_res ? -quo : quo; hi = neg_rem ? -rem : rem (quotient truncates toward zero).
  - done=1 and hilo_write=1 for exactly the cycle after E33; busy=0 from E33; state=IDLE.
- Total latency: done is high 33 cycles after the start edge.
- DZ, at edge E1: done=1 and div_zero=1 for one cycle; hilo_write=0; hi/lo keep previous values; busy=0; state=IDLE.
- Next start may be sampled on the edge that ends the done cycle; back-to-back operations are allowed.
- start while busy=1: ignored, no queueing, operands not relatched.
- op_a/op_b may change after E0 without effect.
- Wrap cases, no flags raised:
  - -2^31 / -1: lo = 0x80000000, hi = 0.
  - mult magnitude 2^62: representable, no special case.
- hi/lo hold their value between completions. Only FIN or reset changes them.
- default/illegal state: go to IDLE with all pulses deasserted.

Test Plan:
1. mult op_a=7, op_b=0xFFFFFFFD (-3) -> 33 cycles later done=hilo_write=1 for one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1..32.
2. div op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
3. div op_a=5, op_b=0 with hi/lo preloaded by a prior mult 3*4 (hi=0, lo=12) -> one cycle after start: done=div_zero=1, hilo_write=0; hi=0, lo=12 unchanged.
4. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
5. Second start pulsed at cycle 10 of a mult with different operands -> ignored; result matches the first operands; done appears exactly once.
6. reset=0 at cycle 15 of a div -> busy=0, hi=lo=0, no done. After release, div 100/7 -> lo=14, hi=2 at latency 33.
